uncached_write_buffer: RTL

//  Parametrised uncached-store path to the DDR write interface: queues CPU stores in a DEPTH-entry

---
 rtl/uncached_write_buffer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uncached_write_buffer.sv
// Uncached store buffer: merges CPU stores per 32-byte line, drains each
// line as af command + two masked 128-bit wdf beats.
//
// Ports: clk, rst (sync, active-high); addr/din/we store request,
// stall back to CPU; af_full/wdf_full FIFO back-pressure; idle when
// empty and not draining; af_addr_din/af_wr_en and
// wdf_din/wdf_mask_din/wdf_wr_en push the af and wdf FIFOs.
module uncached_write_buffer #(
  parameter int DEPTH    = 4,
  parameter bit COALESCE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  addr,
  input  logic [31:0]  din,
  input  logic [3:0]   we,
  input  logic         af_full,
  input  logic         wdf_full,
  output logic         stall,
  output logic         idle,
  output logic [30:0]  af_addr_din,
  output logic         af_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din,
  output logic         wdf_wr_en
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    D_IDLE,
    D_BEAT0,
    D_BEAT1
  } dstate_e;

  logic [22:0]  tag_q  [DEPTH];
  logic [255:0] data_q [DEPTH];
  logic [31:0]  ben_q  [DEPTH];

  logic [PW-1:0] head_q, tail_q, newest;
  logic [CW-1:0] count_q;

  logic [22:0]  out_tag_q;
  logic [255:0] out_data_q;
  logic [31:0]  out_ben_q;

  dstate_e state_q, state_d;

  logic        pop, push, merge;
  logic        store_req, nonempty, full;
  logic [22:0] line_tag;

  logic [PW-1:0] wr_idx;
  logic [255:0]  base_data, wr_data;
  logic [31:0]   base_ben, wr_ben;
  logic [31:0]   old_word, new_word;
  logic [7:0]    wofs;
  logic [4:0]    bofs;

  logic unused_addr;
  assign unused_addr = ^{addr[31:28], addr[1:0]};

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign newest    = (tail_q == '0) ? PW'(DEPTH - 1)
                                    : tail_q - 1'b1;
  assign store_req = |we;
  assign nonempty  = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign line_tag  = addr[27:5];

  // The newest entry is only frozen when it is also the head
  // being popped this cycle.
  assign merge = COALESCE && store_req && nonempty
              && (tag_q[newest] == line_tag)
              && !(pop && (count_q == CW'(1)));

  assign stall = store_req && !merge && full;
  assign push  = store_req && !merge && !full;

  // Word w lives at data[255-32w -: 32], i.e. base (7-w)*32.
  assign wofs = {~addr[4:2], 5'b0};
  assign bofs = {~addr[4:2], 2'b0};

  always_comb begin
    wr_idx    = merge ? newest : tail_q;
    base_data = merge ? data_q[newest] : '0;
    base_ben  = merge ? ben_q[newest] : '0;
    old_word  = base_data[wofs +: 32];
    new_word  = old_word;
    for (int k = 0; k < 4; k++) begin
      if (we[k]) new_word[8*k +: 8] = din[8*k +: 8];
    end
    wr_data = base_data;
    wr_data[wofs +: 32] = new_word;
    wr_ben = base_ben;
    wr_ben[bofs +: 4] = base_ben[bofs +: 4] | we;
  end

  always_ff @(posedge clk) begin
    if (push || merge) begin
      tag_q[wr_idx]  <= line_tag;
      data_q[wr_idx] <= wr_data;
      ben_q[wr_idx]  <= wr_ben;
    end
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    af_wr_en  = 1'b0;
    wdf_wr_en = 1'b0;
    unique case (state_q)
      D_IDLE: begin
        if (nonempty) begin
          pop     = 1'b1;
          state_d = D_BEAT0;
        end
      end
      D_BEAT0: begin
        af_wr_en  = !af_full && !wdf_full;
        wdf_wr_en = af_wr_en;
        if (af_wr_en) state_d = D_BEAT1;
      end
      D_BEAT1: begin
        wdf_wr_en = !wdf_full;
        if (wdf_wr_en) begin
          if (nonempty) begin
            pop     = 1'b1;
            state_d = D_BEAT0;
          end else begin
            state_d = D_IDLE;
          end
        end
      end
      default: state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= D_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      out_tag_q  <= '0;
      out_data_q <= '0;
      out_ben_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_q + CW'(push) - CW'(pop);
      if (push) tail_q <= inc(tail_q);
      if (pop) begin
        head_q     <= inc(head_q);
        out_tag_q  <= tag_q[head_q];
        out_data_q <= data_q[head_q];
        out_ben_q  <= ben_q[head_q];
      end
    end
  end

  assign idle        = !nonempty && (state_q == D_IDLE);
  assign af_addr_din = {6'b0, out_tag_q, 2'b00};

  always_comb begin
    if (state_q == D_BEAT1) begin
      wdf_din      = out_data_q[127:0];
      wdf_mask_din = ~out_ben_q[15:0];
    end else begin
      wdf_din      = out_data_q[255:128];
      wdf_mask_din = ~out_ben_q[31:16];
    end
  end

endmodule
